// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI4-Stream FIFO.
// The FIFO stores each beat as one flat vector laid out, LSB first, as:
//   tdata | tstrb | tkeep | tlast | tid | tdest | tuser
// The functions below give that vector's width and each field's LSB offset,
// so the pack and unpack logic in the top level always agree.
package axi_stream_pkg;

  function automatic int payload_width(int bw, int idw, int dw, int uw);
    return 8*bw + 2*bw + 1 + idw + dw + uw;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int strb_lsb(int bw);
    return 8*bw;
  endfunction

  function automatic int keep_lsb(int bw);
    return 9*bw;
  endfunction

  function automatic int last_lsb(int bw);
    return 10*bw;
  endfunction

  function automatic int id_lsb(int bw);
    return 10*bw + 1;
  endfunction

  function automatic int dest_lsb(int bw, int idw);
    return 10*bw + 1 + idw;
  endfunction

  function automatic int user_lsb(int bw, int idw, int dw);
    return 10*bw + 1 + idw + dw;
  endfunction

endpackage

// File: rtl/axi_stream_fifo_mem.sv
// Storage array for axi_stream_fifo: depth x width registers.
// It has one synchronous write port and one asynchronous read port, and no
// control logic of its own.
// Ports:
//   clk     clock
//   we_i    write enable
//   waddr_i write address
//   wdata_i write data
//   raddr_i read address
//   rdata_o read data (combinational from raddr_i)
module axi_stream_fifo_mem #(
  parameter int depth      = 4,
  parameter int width      = 32,
  parameter int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [width-1:0]      wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [width-1:0]      rdata_o
);

  logic [width-1:0] mem_q [depth];

  // NOTE: the array has no reset. Entries are only read when count says they
  // hold valid data, so resetting them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_stream_fifo.sv
// Synchronous AXI4-Stream FIFO. It buffers the s_* stream and re-presents it
// on the m_* port. s_tready and m_tvalid come from registered state only, so
// there is no combinational path from m_tready to s_tready.
// Ports:
//   clk, resetn       clock; asynchronous active-low reset
//   s_t*              slave stream in (s_tready out)
//   m_t*              master stream out (m_tready in)
//   count             current occupancy, 0..depth
module axi_stream_fifo
  import axi_stream_pkg::*;
#(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int depth      = 4,
  parameter int addr_width = $clog2(depth)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tstrb,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [id_width-1:0]     s_tid,
  input  logic [dest_width-1:0]   s_tdest,
  input  logic [user_width-1:0]   s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*byte_width-1:0] m_tdata,
  output logic [byte_width-1:0]   m_tstrb,
  output logic [byte_width-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [id_width-1:0]     m_tid,
  output logic [dest_width-1:0]   m_tdest,
  output logic [user_width-1:0]   m_tuser,
  output logic [addr_width:0]     count
);

  localparam int pw      = payload_width(byte_width, id_width, dest_width, user_width);
  localparam int data_lo = data_lsb();
  localparam int strb_lo = strb_lsb(byte_width);
  localparam int keep_lo = keep_lsb(byte_width);
  localparam int last_lo = last_lsb(byte_width);
  localparam int id_lo   = id_lsb(byte_width);
  localparam int dest_lo = dest_lsb(byte_width, id_width);
  localparam int user_lo = user_lsb(byte_width, id_width, dest_width);

  localparam logic [addr_width:0] full_count = (addr_width+1)'(depth);

  logic [1:0]            rst_sync_q;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  push, pop;
  logic [pw-1:0]         wdata, rdata;

  // Reset asserts immediately but is released through two flops, so s_tready
  // stays low for two cycles after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign s_tready = rst_sync_q[1] && (count_q != full_count);
  assign m_tvalid = (count_q != '0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;
  assign count    = count_q;

  // NOTE: combinational next-state uses blocking assignments with every
  // output defaulted first, so no path can leave a latch behind.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + addr_width'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + addr_width'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (addr_width+1)'(1);
      2'b01:   count_d = count_q - (addr_width+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The stored strobe is masked by keep, so TSTRB is never set on a null byte.
  assign wdata = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb & s_tkeep, s_tdata};

  axi_stream_fifo_mem #(
    .depth      (depth),
    .width      (pw),
    .addr_width (addr_width)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign m_tdata = rdata[data_lo +: 8*byte_width];
  assign m_tstrb = rdata[strb_lo +: byte_width];
  assign m_tkeep = rdata[keep_lo +: byte_width];
  assign m_tlast = rdata[last_lo];
  assign m_tid   = rdata[id_lo   +: id_width];
  assign m_tdest = rdata[dest_lo +: dest_width];
  assign m_tuser = rdata[user_lo +: user_width];

endmodule

`ifdef FORMAL
bind axi_stream_fifo axi_stream_master_monitor #(
  .byte_width (byte_width),
  .id_width   (id_width),
  .dest_width (dest_width),
  .user_width (user_width)
) u_m_monitor (
  .clk    (clk),
  .resetn (resetn),
  .tvalid (m_tvalid),
  .tready (m_tready),
  .tdata  (m_tdata),
  .tstrb  (m_tstrb),
  .tkeep  (m_tkeep),
  .tlast  (m_tlast),
  .tid    (m_tid),
  .tdest  (m_tdest),
  .tuser  (m_tuser)
);

bind axi_stream_fifo axi_stream_slave_monitor #(
  .byte_width (byte_width),
  .id_width   (id_width),
  .dest_width (dest_width),
  .user_width (user_width)
) u_s_monitor (
  .clk    (clk),
  .resetn (resetn),
  .tvalid (s_tvalid),
  .tready (s_tready),
  .tdata  (s_tdata),
  .tstrb  (s_tstrb),
  .tkeep  (s_tkeep),
  .tlast  (s_tlast),
  .tid    (s_tid),
  .tdest  (s_tdest),
  .tuser  (s_tuser)
);
`endif

// File: tb/tb_axi_stream_fifo.sv
// Directed bench for axi_stream_fifo at its default parameters (4-byte data,
// depth 4). Inputs change on the falling edge and outputs are sampled there.
module tb_axi_stream_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb, s_tkeep;
  logic        s_tlast;
  logic [0:0]  s_tid, s_tdest, s_tuser;
  logic        m_tvalid, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb, m_tkeep;
  logic        m_tlast;
  logic [0:0]  m_tid, m_tdest, m_tuser;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_stream_fifo dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tid    (s_tid),
    .s_tdest  (s_tdest),
    .s_tuser  (s_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tdest  (m_tdest),
    .m_tuser  (m_tuser),
    .count    (count)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock: the rising edge acts, then we return at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    resetn   = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'hA5A5_A5A5;
    s_tstrb  = 4'hF;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    s_tid    = 1'b0;
    s_tdest  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b0;

    // Reset held, then released with s_tvalid already high.
    repeat (3) step();
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_count",    64'(count),    64'd0);
    resetn = 1'b1;
    step();
    check("rel1_s_tready", 64'(s_tready), 64'd0);
    step();
    check("rel2_s_tready", 64'(s_tready), 64'd1);
    check("rel2_m_tvalid", 64'(m_tvalid), 64'd0);
    step();
    check("first_m_tvalid", 64'(m_tvalid), 64'd1);
    check("first_m_tdata",  64'(m_tdata),  64'hA5A5_A5A5);
    check("first_count",    64'(count),    64'd1);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    check("drain0_count",    64'(count),    64'd0);
    check("drain0_m_tvalid", 64'(m_tvalid), 64'd0);
    m_tready = 1'b0;

    // Fill to full with the consumer stalled; word 5 is held at the slave.
    s_tvalid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_tdata = 32'(i);
      step();
      check("fill_count",   64'(count),   64'(i));
      check("fill_m_tdata", 64'(m_tdata), 64'h1);
    end
    s_tdata = 32'h5;
    check("full_s_tready", 64'(s_tready), 64'd0);
    repeat (2) begin
      step();
      check("hold_count",    64'(count),    64'd4);
      check("hold_s_tready", 64'(s_tready), 64'd0);
      check("hold_m_tdata",  64'(m_tdata),  64'h1);
    end

    // One pop from full frees a slot; word 5 enters on the following cycle.
    m_tready = 1'b1;
    step();
    check("pop1_count",    64'(count),    64'd3);
    check("pop1_s_tready", 64'(s_tready), 64'd1);
    check("pop1_m_tdata",  64'(m_tdata),  64'h2);
    m_tready = 1'b0;
    step();
    check("refill_count",    64'(count),    64'd4);
    check("refill_s_tready", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("order_m_tvalid", 64'(m_tvalid), 64'd1);
      check("order_m_tdata",  64'(m_tdata),  64'(i));
      step();
    end
    check("order_empty_count", 64'(count), 64'd0);

    // Streaming with both sides always ready: one word per cycle, count at 1.
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 32'h100 + 32'(i);
      step();
      check("stream_count",  64'(count),   64'd1);
      check("stream_m_tdata", 64'(m_tdata), 64'h100 + 64'(i));
    end
    s_tvalid = 1'b0;
    step();
    check("stream_end_count", 64'(count), 64'd0);

    // Strobe sanitising and transparent sideband.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'hDEAD_BEEF;
    s_tkeep  = 4'b0011;
    s_tstrb  = 4'b1111;
    s_tlast  = 1'b1;
    s_tid    = 1'b1;
    s_tdest  = 1'b1;
    s_tuser  = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("san_m_tstrb", 64'(m_tstrb), 64'h3);
    check("san_m_tkeep", 64'(m_tkeep), 64'h3);
    check("san_m_tlast", 64'(m_tlast), 64'd1);
    check("san_m_tid",   64'(m_tid),   64'd1);
    check("san_m_tdest", 64'(m_tdest), 64'd1);
    check("san_m_tuser", 64'(m_tuser), 64'd1);
    check("san_m_tdata", 64'(m_tdata), 64'hDEAD_BEEF);
    s_tkeep = 4'hF;
    s_tstrb = 4'hF;
    s_tlast = 1'b0;
    s_tid   = 1'b0;
    s_tdest = 1'b0;
    s_tuser = 1'b0;
    m_tready = 1'b1;
    step();
    check("san_drain_count", 64'(count), 64'd0);
    m_tready = 1'b0;

    // Asynchronous reset pulse between edges with three words buffered.
    s_tvalid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_tdata = 32'h11 * 32'(i);
      step();
    end
    s_tvalid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd3);
    #2 resetn = 1'b0;
    #1;
    check("async_m_tvalid", 64'(m_tvalid), 64'd0);
    check("async_s_tready", 64'(s_tready), 64'd0);
    check("async_count",    64'(count),    64'd0);
    @(negedge clk);
    check("inrst_m_tvalid", 64'(m_tvalid), 64'd0);
    resetn   = 1'b1;
    m_tready = 1'b1;
    step();
    check("post1_m_tvalid", 64'(m_tvalid), 64'd0);
    check("post1_s_tready", 64'(s_tready), 64'd0);
    step();
    check("post2_m_tvalid", 64'(m_tvalid), 64'd0);
    check("post2_s_tready", 64'(s_tready), 64'd1);
    check("post2_count",    64'(count),    64'd0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h44;
    step();
    s_tvalid = 1'b0;
    check("post_push_count",  64'(count),   64'd1);
    check("post_push_m_tdata", 64'(m_tdata), 64'h44);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_stream_fifo.md
Name: axi_stream_fifo

Overview:
Synchronous AXI4-Stream FIFO. It buffers a slave-side stream and re-presents it on a master port that is fully AXI4-Stream compliant, including handshake stability, reset behaviour and TKEEP/TSTRB legality. It sits directly upstream of any consumer whose input is checked by the team's AXI-Stream master-port property set. It decouples producer and consumer: there is no combinational path from m_tready to s_tready.

Parameters:
byte_width, 4, TDATA width in bytes; TDATA is 8*byte_width bits, TKEEP/TSTRB are byte_width bits
id_width, 1, TID width; must be >=1 (tie off if unused)
dest_width, 1, TDEST width; must be >=1
user_width, 1, TUSER width; must be >=1
depth, 4, number of entries; power of two, >=2
addr_width, $clog2(depth), pointer width; derived, do not override

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk
s_tvalid  in  1  slave valid
s_tready  out  1  slave ready
s_tdata  in  8*byte_width  slave data
s_tstrb  in  byte_width  slave byte strobe
s_tkeep  in  byte_width  slave byte keep
s_tlast  in  1  slave packet end
s_tid  in  id_width  slave stream ID
s_tdest  in  dest_width  slave destination
s_tuser  in  user_width  slave sideband
m_tvalid  out  1  master valid
m_tready  in  1  master ready
m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  (as slave)  master payload
count  out  addr_width+1  current occupancy, 0..depth

Behaviour:
- Reset (resetn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Therefore m_tvalid=0 and s_tready=0 while in reset. Storage array is not reset; m_t* payload is don't-care while m_tvalid=0.
- s_tready = resetn_sync && (count != depth), driven from registered state only. resetn_sync is a 2-flop internal synchronised release. s_tready stays 0 for 2 cycles after resetn rises.
- m_tvalid = (count != 0), registered state only.
- Push = s_tvalid && s_tready. On push, the payload is written to mem[wr_ptr] and wr_ptr increments.
- Stored tstrb = s_tstrb & s_tkeep. This sanitises the output so TSTRB is never set where TKEEP is clear.
- Pop = m_tvalid && m_tready. On pop, rd_ptr increments.
- m_t* payload = mem[rd_ptr], a combinational read of the register array. It is stable while m_tvalid && !m_tready because rd_ptr and that entry are unchanged.
- Latency: a word pushed at edge N appears with m_tvalid=1 after edge N. There is no same-cycle bypass when empty.
- count next-state:
  - push && !pop: count+1
  - pop && !push: count-1
  - both or neither: unchanged
- Pointers wrap modulo depth (natural addr_width overflow).
- Full (count==depth): s_tready=0, so no push. A pop in the same cycle frees a slot, and s_tready rises the next cycle.
- Empty (count==0): m_tvalid=0, so no pop. A push in the same cycle makes m_tvalid rise the next cycle.
- Simultaneous push and pop at 0<count<depth: both pointers advance and count is held.
- Once m_tvalid=1 it only falls after a pop or reset; the FIFO never withdraws data.
- Reset mid-stream: all buffered words are discarded. Partial packets are not completed; tlast framing is the producer's responsibility after reset.
- No packet awareness: tlast, tid, tdest and tuser are carried transparently as data.

Decomposition:
- axi_stream_pkg:
  - payload_width function: 8*bw + 2*bw + 1 + id + dest + user
  - pack/unpack field offset constants so the payload is stored as one flat vector
- Sub-module axi_stream_fifo_mem: depth x payload_width register array with one write port (we, waddr, wdata) and one asynchronous read port. It contains no control logic.
- Top level holds pointers, count, the reset synchroniser and the sanitisation logic.
- Bind axi_stream_master_monitor to the m_* port, and the slave-side counterpart to the s_* port, in formal builds.

Test Plan:
- Reset release, s_tvalid=1 held: s_tready=0 for 2 cycles after resetn rises, then 1. The first word 0xA5A5A5A5 appears on m_tdata with m_tvalid=1 one cycle after the push.
- depth=4, m_tready=0, push 0x1,0x2,0x3,0x4,0x5 back-to-back: count reaches 4, s_tready=0, word 0x5 is held at the slave. m_tdata stays 0x1 every cycle.
- From full, m_tready=1 for one cycle: 0x1 popped; next cycle s_tready=1, 0x5 is accepted, count is back to 4. Output order is 0x2,0x3,0x4,0x5 with no loss or duplication.
- Continuous s_tvalid=1 and m_tready=1 for 20 cycles with an incrementing pattern: after the first word, throughput is 1 word/cycle, count stays 1, the output sequence matches the input, and the pointers wrap cleanly.
- Push s_tkeep=4'b0011, s_tstrb=4'b1111, tlast=1, tid=1, tdest=1, tuser=1: output is m_tstrb=4'b0011, m_tkeep=4'b0011, with tlast/tid/tdest/tuser=1.
- Asynchronous resetn pulse mid-cycle with count=3: m_tvalid and s_tready drop immediately, count=0. After release no stale word is emitted and the monitor property !tvalid-in-reset holds.
